heap_req_scheduler: RTL



---
 rtl/heap_sched_pkg.sv | 24 ++
 rtl/heap_req_scheduler_if.sv | 30 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/heap_req_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/heap_sched_pkg.sv
// Shared encodings for the heap request scheduler: command ops, response
// error codes and the scheduler FSM state type.
package heap_sched_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_FULL    = 2'd1;
    localparam logic [1:0] ERR_EMPTY   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    function automatic logic [31:0] zext_key(input logic [7:0] key);
        return {24'd0, key};
    endfunction

endpackage

// File: rtl/heap_req_scheduler_if.sv
// Requester/response bus between the instruction pipeline (master) and the
// heap request scheduler (slave).
interface heap_req_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_v;
    logic [NUM_REQ-1:0]   req_op;
    logic [8*NUM_REQ-1:0] req_data;
    logic [5*NUM_REQ-1:0] req_rd;
    logic [NUM_REQ-1:0]   req_gnt;

    logic                 rsp_v;
    logic [IDW-1:0]       rsp_id;
    logic [4:0]           rsp_rd;
    logic [31:0]          rsp_data;
    logic [1:0]           rsp_err;

    modport master (
        output req_v, req_op, req_data, req_rd,
        input  req_gnt, rsp_v, rsp_id, rsp_rd, rsp_data, rsp_err
    );

    modport slave (
        input  req_v, req_op, req_data, req_rd,
        output req_gnt, rsp_v, rsp_id, rsp_rd, rsp_data, rsp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping; the pointer register lives in the caller.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          found
);

    int            sum;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            sum = int'(ptr) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = IW'(sum);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/heap_req_scheduler.sv
// Arbitrates NUM_REQ requesters onto one max-heap engine, one command in
// flight at a time, with local occupancy tracking and tagged responses.
module heap_req_scheduler
    import heap_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int HEAP_SIZE = 25,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = $clog2(HEAP_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    heap_req_scheduler_if.slave   bus,
    output logic                  heap_push,
    output logic                  heap_pop,
    output logic [7:0]            heap_din,
    input  logic                  heap_idle,
    input  logic [7:0]            heap_dout,
    output logic [CNT_W-1:0]      occupancy,
    output logic                  full,
    output logic                  empty
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    sched_state_t        state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q;
    logic [CNT_W-1:0]    occ_q;
    logic [TMO_W-1:0]    tmo_q;

    logic                arb_en;
    logic [NUM_REQ-1:0]  gnt_vec;
    logic [IDW-1:0]      gnt_idx;
    logic                gnt_any;
    logic                gnt_op;
    logic [7:0]          gnt_data;
    logic [4:0]          gnt_rd;

    logic [IDW-1:0]      cmd_id_q;
    logic                cmd_op_q;
    logic [7:0]          cmd_data_q;
    logic [4:0]          cmd_rd_q;

    logic                rsp_load;
    logic [IDW-1:0]      rsp_id_d;
    logic [4:0]          rsp_rd_d;
    logic [31:0]         rsp_data_d;
    logic [1:0]          rsp_err_d;
    logic                occ_inc, occ_dec;

    logic                rsp_v_q;
    logic [IDW-1:0]      rsp_id_q;
    logic [4:0]          rsp_rd_q;
    logic [31:0]         rsp_data_q;
    logic [1:0]          rsp_err_q;

    assign occupancy = occ_q;
    assign full      = (occ_q == CNT_W'(HEAP_SIZE));
    assign empty     = (occ_q == '0);

    // Grants are only offered while idle and the engine has finished its last heapify.
    assign arb_en = (state_q == ST_IDLE) && heap_idle && !reset;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_arb (
        .req   (bus.req_v),
        .en    (arb_en),
        .ptr   (rr_ptr_q),
        .gnt   (gnt_vec),
        .idx   (gnt_idx),
        .found (gnt_any)
    );

    assign bus.req_gnt = gnt_vec;

    always_comb begin
        gnt_op   = 1'b0;
        gnt_data = '0;
        gnt_rd   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                gnt_op   = bus.req_op[i];
                gnt_data = bus.req_data[8*i +: 8];
                gnt_rd   = bus.req_rd[5*i +: 5];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        heap_push  = 1'b0;
        heap_pop   = 1'b0;
        heap_din   = '0;
        rsp_load   = 1'b0;
        rsp_id_d   = cmd_id_q;
        rsp_rd_d   = cmd_rd_q;
        rsp_data_d = '0;
        rsp_err_d  = ERR_OK;
        occ_inc    = 1'b0;
        occ_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    rsp_id_d = gnt_idx;
                    rsp_rd_d = gnt_rd;
                    if (gnt_op == OP_PUSH && full) begin
                        state_d   = ST_RESP;
                        rsp_load  = 1'b1;
                        rsp_err_d = ERR_FULL;
                    end else if (gnt_op == OP_POP && empty) begin
                        state_d   = ST_RESP;
                        rsp_load  = 1'b1;
                        rsp_err_d = ERR_EMPTY;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                heap_push = (cmd_op_q == OP_PUSH);
                heap_pop  = (cmd_op_q == OP_POP);
                heap_din  = cmd_data_q;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (heap_idle) begin
                    state_d  = ST_RESP;
                    rsp_load = 1'b1;
                    if (cmd_op_q == OP_POP) begin
                        rsp_data_d = zext_key(heap_dout);
                        occ_dec    = !empty;
                    end else begin
                        occ_inc    = !full;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d   = ST_RESP;
                    rsp_load  = 1'b1;
                    rsp_err_d = ERR_TIMEOUT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            occ_q      <= '0;
            tmo_q      <= '0;
            rsp_v_q    <= 1'b0;
            rsp_id_q   <= '0;
            rsp_rd_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= ERR_OK;
        end else begin
            state_q <= state_d;
            rsp_v_q <= rsp_load;
            if (gnt_any) begin
                rr_ptr_q <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (state_q == ST_ISSUE) begin
                tmo_q <= '0;
            end else if (state_q == ST_WAIT) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (rsp_load) begin
                rsp_id_q   <= rsp_id_d;
                rsp_rd_q   <= rsp_rd_d;
                rsp_data_q <= rsp_data_d;
                rsp_err_q  <= rsp_err_d;
            end
            // Occupancy moves on entry to RESP so the response cycle already shows it.
            if (occ_inc) begin
                occ_q <= occ_q + 1'b1;
            end else if (occ_dec) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_any) begin
            cmd_id_q   <= gnt_idx;
            cmd_op_q   <= gnt_op;
            cmd_data_q <= gnt_data;
            cmd_rd_q   <= gnt_rd;
        end
    end

    assign bus.rsp_v    = rsp_v_q;
    assign bus.rsp_id   = rsp_id_q;
    assign bus.rsp_rd   = rsp_rd_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;

endmodule
